acq_line_ctrl: RTL and testbench

- Acquisition controller for swept-source OCT on DE4: arms on a host start pulse, waits for laser sweep triggers and captures a fixed number of ADC samples per A-line.
- Writes samples sequentially into the line buffer and raises acq_done when the programmed number of A-lines is stored.
- acq_done is a level that feeds directly into the acquisition-done PIO input port, which the host polls.

---
 rtl/acq_line_ctrl.sv | 151 +++++++++++++++
 tb/tb_acq_line_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_line_ctrl.sv
// Swept-source OCT acquisition controller: arms on start, captures num_samples
// ADC words per laser sweep trigger into a linear line buffer, flags done.
`timescale 1ns/1ps
module acq_line_ctrl #(
    parameter int SAMPLE_W = 14,
    parameter int ADDR_W   = 16,
    parameter int NS_W     = 12,
    parameter int NL_W     = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [NS_W-1:0]     num_samples,
    input  logic [NL_W-1:0]     num_lines,
    input  logic                trig,
    input  logic                adc_valid,
    input  logic [SAMPLE_W-1:0] adc_data,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [SAMPLE_W-1:0] wr_data,
    output logic                busy,
    output logic                acq_done,
    output logic                overrun
);

    typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;

    state_t              state_q, state_d;
    logic                s1_q, s2_q, s3_q, trig_rise_q;
    logic [NS_W-1:0]     ns_q, ns_d, sample_q, sample_d;
    logic [NL_W-1:0]     nl_q, nl_d, line_q, line_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [SAMPLE_W-1:0] wr_data_q, wr_data_d;
    logic                wr_en_q, wr_en_d, busy_q, busy_d;
    logic                done_q, done_d, ovr_q, ovr_d;

    // Trigger synchronizer plus registered rising-edge detect (s3 holds previous s2).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            trig_rise_q <= 1'b0;
        end else begin
            s1_q        <= trig;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            trig_rise_q <= s2_q & ~s3_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ns_q      <= '0;
            nl_q      <= '0;
            sample_q  <= '0;
            line_q    <= '0;
            addr_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ns_q      <= ns_d;
            nl_q      <= nl_d;
            sample_q  <= sample_d;
            line_q    <= line_d;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ns_d      = ns_q;
        nl_d      = nl_q;
        sample_d  = sample_q;
        line_d    = line_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        ovr_d     = ovr_q;

        // abort outranks start, trigger and last-sample handling
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        ns_d      = num_samples;
                        nl_d      = num_lines;
                        ovr_d     = 1'b0;
                        addr_d    = '0;
                        wr_addr_d = '0;
                        sample_d  = '0;
                        line_d    = '0;
                        state_d   = (num_samples == '0 || num_lines == '0) ? DONE : WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (trig_rise_q) begin
                        sample_d = '0;
                        state_d  = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (trig_rise_q) begin
                        ovr_d = 1'b1;
                    end
                    if (adc_valid) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = adc_data;
                        addr_d    = addr_q + 1'b1;
                        if (sample_q == ns_q - 1'b1) begin
                            sample_d = '0;
                            line_d   = line_q + 1'b1;
                            state_d  = (line_q == nl_q - 1'b1) ? DONE : WAIT_TRIG;
                        end else begin
                            sample_d = sample_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == WAIT_TRIG) || (state_d == CAPTURE);
        done_d = (state_d == DONE);
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign acq_done = done_q;
    assign overrun  = ovr_q;

endmodule

// File: tb/tb_acq_line_ctrl.sv
// Randomized bench for acq_line_ctrl: expected writes are derived from the
// addressing rule addr = line*num_samples + sample and the driven sample data.
`timescale 1ns/1ps
module tb_acq_line_ctrl;

    localparam int SAMPLE_W = 14;
    localparam int ADDR_W   = 16;
    localparam int NS_W     = 12;
    localparam int NL_W     = 10;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [NS_W-1:0]     num_samples = '0;
    logic [NL_W-1:0]     num_lines = '0;
    logic                trig = 1'b0;
    logic                adc_valid = 1'b0;
    logic [SAMPLE_W-1:0] adc_data = '0;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [SAMPLE_W-1:0] wr_data;
    logic                busy;
    logic                acq_done;
    logic                overrun;

    acq_line_ctrl #(
        .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W), .NS_W(NS_W), .NL_W(NL_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .num_samples(num_samples), .num_lines(num_lines), .trig(trig),
        .adc_valid(adc_valid), .adc_data(adc_data), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .acq_done(acq_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // observed writes, with the done/busy levels seen alongside each one
    logic [ADDR_W-1:0]   ga_q[$];
    logic [SAMPLE_W-1:0] gd_q[$];
    logic                gdone_q[$];
    logic                gbusy_q[$];
    // expected writes from the reference model
    logic [ADDR_W-1:0]   ea_q[$];
    logic [SAMPLE_W-1:0] ed_q[$];

    always @(negedge clk) begin
        if (reset_n && wr_en) begin
            ga_q.push_back(wr_addr);
            gd_q.push_back(wr_data);
            gdone_q.push_back(acq_done);
            gbusy_q.push_back(busy);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        ga_q.delete(); gd_q.delete(); gdone_q.delete(); gbusy_q.delete();
        ea_q.delete(); ed_q.delete();
    endtask

    task automatic do_start(input int ns, input int nl);
        num_samples = ns[NS_W-1:0];
        num_lines   = nl[NL_W-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // one-cycle raw pulse, then enough idle cycles for the synchronized edge to act
    task automatic trig_pulse();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (4) tick();
    endtask

    task automatic feed_line(input int line, input int ns, input int cnt,
                             input bit gaps, input bit fixed, input int fdata);
        logic [31:0] r;
        int a;
        for (int s = 0; s < cnt; s++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    adc_valid = 1'b0;
                    r = $urandom;
                    adc_data = r[SAMPLE_W-1:0];
                    tick();
                end
            end
            r = fixed ? 32'(fdata + s) : $urandom;
            a = line * ns + s;
            adc_valid = 1'b1;
            adc_data  = r[SAMPLE_W-1:0];
            ea_q.push_back(a[ADDR_W-1:0]);
            ed_q.push_back(r[SAMPLE_W-1:0]);
            tick();
        end
        adc_valid = 1'b0;
    endtask

    task automatic compare_writes(input string tag, input bit final_done);
        int n;
        bit last;
        n = ea_q.size();
        check_eq({tag, "_count"}, ga_q.size(), n);
        for (int i = 0; i < n && i < ga_q.size(); i++) begin
            last = final_done && (i == n - 1);
            check_eq({tag, "_addr"}, ga_q[i], ea_q[i]);
            check_eq({tag, "_data"}, gd_q[i], ed_q[i]);
            check_eq({tag, "_done_at_wr"}, gdone_q[i], last);
            check_eq({tag, "_busy_at_wr"}, gbusy_q[i], !last);
        end
        clear_queues();
    endtask

    task automatic run_acq(input string tag, input int ns, input int nl,
                           input bit gaps, input int ovr_line);
        do_start(ns, nl);
        check_eq({tag, "_ovr_cleared"}, overrun, 0);
        check_eq({tag, "_busy_armed"}, busy, 1);
        check_eq({tag, "_done_armed"}, acq_done, 0);
        for (int l = 0; l < nl; l++) begin
            trig_pulse();
            if (l == ovr_line) trig_pulse();
            feed_line(l, ns, ns, gaps, 1'b0, 0);
        end
        tick();
        compare_writes(tag, 1'b1);
        check_eq({tag, "_done"}, acq_done, 1);
        check_eq({tag, "_busy_end"}, busy, 0);
        check_eq({tag, "_overrun"}, overrun, (ovr_line >= 0 && ovr_line < nl));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ns, nl, ovr;
        logic [31:0] r;

        repeat (3) tick();
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", acq_done, 0);
        check_eq("rst_overrun", overrun, 0);
        reset_n = 1'b1;
        tick();

        // basic two-line capture with known data
        do_start(4, 2);
        check_eq("basic_busy", busy, 1);
        trig_pulse();
        feed_line(0, 4, 4, 1'b0, 1'b1, 32'h10);
        trig_pulse();
        feed_line(1, 4, 4, 1'b0, 1'b1, 32'h20);
        tick();
        compare_writes("basic", 1'b1);
        check_eq("basic_done", acq_done, 1);

        // stalled data with an overrun on line 0, then a clean run clears overrun
        run_acq("stall_ovr", 5, 2, 1'b1, 0);
        run_acq("after_ovr", 3, 1, 1'b0, -1);

        for (int it = 0; it < 6; it++) begin
            ns = $urandom_range(1, 6);
            nl = $urandom_range(1, 3);
            ovr = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nl - 1) : -1;
            run_acq("rand", ns, nl, $urandom_range(0, 1) == 1, ovr);
        end

        // zero configuration goes straight to done with no writes
        do_start(5, 0);
        check_eq("zero_nl_done", acq_done, 1);
        check_eq("zero_nl_busy", busy, 0);
        trig_pulse();
        adc_valid = 1'b1;
        repeat (3) tick();
        adc_valid = 1'b0;
        tick();
        check_eq("zero_nl_writes", ga_q.size(), 0);
        do_start(0, 3);
        check_eq("zero_ns_done", acq_done, 1);
        check_eq("zero_ns_busy", busy, 0);

        // start together with abort from DONE lands in IDLE
        num_samples = 2; num_lines = 1;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_eq("sa_done", acq_done, 0);
        check_eq("sa_busy", busy, 0);
        trig_pulse();
        adc_valid = 1'b1;
        repeat (3) tick();
        adc_valid = 1'b0;
        tick();
        check_eq("sa_writes", ga_q.size(), 0);
        clear_queues();

        // start while waiting for a trigger must not re-latch the settings
        do_start(3, 1);
        num_samples = 7; num_lines = 5;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("ign_busy", busy, 1);
        trig_pulse();
        feed_line(0, 3, 3, 1'b1, 1'b0, 0);
        tick();
        compare_writes("ign_start", 1'b1);
        check_eq("ign_done", acq_done, 1);

        // abort after two of four samples
        do_start(4, 1);
        trig_pulse();
        feed_line(0, 4, 2, 1'b0, 1'b0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", acq_done, 0);
        adc_valid = 1'b1;
        repeat (3) tick();
        adc_valid = 1'b0;
        tick();
        check_eq("abort_wr_en", wr_en, 0);
        compare_writes("abort", 1'b0);

        // asynchronous reset in the middle of a capture
        do_start(8, 1);
        trig_pulse();
        adc_valid = 1'b1;
        r = $urandom;
        adc_data = r[SAMPLE_W-1:0] | 14'h1;
        repeat (3) tick();
        check_eq("pre_rst_wr_en", wr_en, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_wr_en", wr_en, 0);
        check_eq("arst_wr_addr", wr_addr, 0);
        check_eq("arst_wr_data", wr_data, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", acq_done, 0);
        check_eq("arst_overrun", overrun, 0);
        adc_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        clear_queues();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
